// File: rtl/serial_restador_pkg.sv
// rtl/serial_restador_pkg.sv - shared state encoding and defaults for serial_restador
package serial_restador_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/full_restador.sv
// rtl/full_restador.sv - combinational 1-bit full subtractor (d = a - b - bi)
module full_restador (
   input  logic a,
   input  logic b,
   input  logic bi,
   output logic d,
   output logic bo
);

   // difference and borrow of a single bit position
   always_comb begin
      d  = a ^ b ^ bi;
      bo = (~a & b) | (~(a ^ b) & bi);
   end

endmodule

// File: rtl/serial_restador.sv
// rtl/serial_restador.sv - bit-serial subtractor D = A - B - BI, LSB first; optional signed overflow via SERIAL_RESTADOR_OVF_EN
module serial_restador
   import serial_restador_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_bi,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out_d,
   output logic             out_bo
`ifdef SERIAL_RESTADOR_OVF_EN
   ,
   output logic             out_ov
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   // a_q doubles as the result register: difference bits enter at the MSB
   // as the minuend bits leave at the LSB, so after WIDTH shifts it holds D.
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             br_q, br_d;
   logic [WIDTH-1:0] out_d_q, out_d_d;
   logic             out_bo_q, out_bo_d;
   logic             fs_d, fs_bo;
`ifdef SERIAL_RESTADOR_OVF_EN
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic             ov_q, ov_d;
`endif

   full_restador u_full_restador (
      .a  (a_q[0]),
      .b  (b_q[0]),
      .bi (br_q),
      .d  (fs_d),
      .bo (fs_bo)
   );

   // next-state, datapath and output-register update
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      br_d     = br_q;
      out_d_d  = out_d_q;
      out_bo_d = out_bo_q;
`ifdef SERIAL_RESTADOR_OVF_EN
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      ov_d     = ov_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = in_a;
               b_d     = in_b;
               br_d    = in_bi;
               cnt_d   = '0;
`ifdef SERIAL_RESTADOR_OVF_EN
               a_msb_d = in_a[WIDTH-1];
               b_msb_d = in_b[WIDTH-1];
`endif
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            a_d   = {fs_d, a_q[WIDTH-1:1]};
            b_d   = {1'b0, b_q[WIDTH-1:1]};
            br_d  = fs_bo;
            cnt_d = cnt_q + CNT_ONE;
            // the last bit completes the word: publish it only now so a
            // partial difference never reaches out_d
            if (cnt_q == CNT_LAST) begin
               out_d_d  = {fs_d, a_q[WIDTH-1:1]};
               out_bo_d = fs_bo;
`ifdef SERIAL_RESTADOR_OVF_EN
               ov_d     = (a_msb_q ^ b_msb_q) & (a_msb_q ^ fs_d);
`endif
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // state and datapath registers, cleared immediately by rst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         br_q     <= 1'b0;
         out_d_q  <= '0;
         out_bo_q <= 1'b0;
`ifdef SERIAL_RESTADOR_OVF_EN
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         ov_q     <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         br_q     <= br_d;
         out_d_q  <= out_d_d;
         out_bo_q <= out_bo_d;
`ifdef SERIAL_RESTADOR_OVF_EN
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         ov_q     <= ov_d;
`endif
      end
   end

   assign busy   = (state_q == ST_SHIFT);
   assign done   = (state_q == ST_DONE);
   assign out_d  = out_d_q;
   assign out_bo = out_bo_q;
`ifdef SERIAL_RESTADOR_OVF_EN
   assign out_ov = ov_q;
`endif

endmodule

// File: tb/tb_serial_restador.sv
// tb/tb_serial_restador.sv - directed self-checking bench for serial_restador (WIDTH=4)
module tb_serial_restador;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_bi;
   logic         busy;
   logic         done;
   logic [W-1:0] out_d;
   logic         out_bo;
`ifdef SERIAL_RESTADOR_OVF_EN
   logic         out_ov;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt = 0;

   serial_restador #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .in_a   (in_a),
      .in_b   (in_b),
      .in_bi  (in_bi),
      .busy   (busy),
      .done   (done),
      .out_d  (out_d),
      .out_bo (out_bo)
`ifdef SERIAL_RESTADOR_OVF_EN
      ,
      .out_ov (out_ov)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (done === 1'b1) done_cnt++;
   end

   // drive one operation from IDLE or DONE; returns busy cycles seen before done
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                         output int nbusy, output logic seen);
      @(negedge clk);
      in_a = a; in_b = b; in_bi = bi; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nbusy = 0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (busy === 1'b1) nbusy++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; in_a = '0; in_b = '0; in_bi = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({busy, done, out_d, out_bo} !== 7'b0) begin
         n_err++;
         $display("FAIL reset_outputs: got %b expected %b", {busy, done, out_d, out_bo}, 7'b0);
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_err++;
         $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy, done);
      end
   endtask

   task automatic test_directed;
      int nb;
      logic seen;
      run_op(4'd9, 4'd3, 1'b0, nb, seen);
      n_cmp++;
      if (!seen || nb != 4 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL latency_9m3: got done=%b busy_cycles=%0d busy_at_done=%b expected 1 4 0", seen, nb, busy);
      end
      n_cmp++;
      if (out_d !== 4'd6 || out_bo !== 1'b0) begin
         n_err++;
         $display("FAIL result_9m3: got d=%0d bo=%b expected d=6 bo=0", out_d, out_bo);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || out_d !== 4'd6) begin
         n_err++;
         $display("FAIL done_one_cycle: got done=%b d=%0d expected done=0 d=6", done, out_d);
      end
      run_op(4'd3, 4'd9, 1'b0, nb, seen);
      n_cmp++;
      if (!seen || out_d !== 4'hA || out_bo !== 1'b1) begin
         n_err++;
         $display("FAIL result_3m9: got done=%b d=%0d bo=%b expected 1 10 1", seen, out_d, out_bo);
      end
      run_op(4'd0, 4'd0, 1'b1, nb, seen);
      n_cmp++;
      if (!seen || out_d !== 4'hF || out_bo !== 1'b1) begin
         n_err++;
         $display("FAIL wrap_0m0m1: got done=%b d=%0d bo=%b expected 1 15 1", seen, out_d, out_bo);
      end
   endtask

   task automatic test_exhaustive;
      int nb;
      logic seen;
      int start_cnt;
      logic [W-1:0] ea, eb, ed;
      logic ebo;
      @(negedge clk);
      start_cnt = done_cnt;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int bi = 0; bi < 2; bi++) begin
               ea = W'(a);
               eb = W'(b);
               ed = ea + ~eb + ((bi == 0) ? 4'd1 : 4'd0);
               ebo = (a < b + bi);
               run_op(ea, eb, bi[0], nb, seen);
               n_cmp++;
               if (!seen || out_d !== ed || out_bo !== ebo) begin
                  n_err++;
                  $display("FAIL exhaustive a=%0d b=%0d bi=%0d: got done=%b d=%0d bo=%b expected 1 %0d %b",
                           a, b, bi, seen, out_d, out_bo, ed, ebo);
               end
            end
         end
      end
      @(negedge clk);
      n_cmp++;
      if (done_cnt - start_cnt != 512) begin
         n_err++;
         $display("FAIL exhaustive_done_count: got %0d expected 512", done_cnt - start_cnt);
      end
   endtask

   task automatic test_start_held;
      logic [W-1:0] ops_a [3];
      logic [W-1:0] ops_b [3];
      logic         ops_bi[3];
      logic [W-1:0] exp_d [3];
      logic         exp_bo[3];
      int ndone;
      ops_a = '{4'd9, 4'd3, 4'd0};
      ops_b = '{4'd3, 4'd9, 4'd0};
      ops_bi = '{1'b0, 1'b0, 1'b1};
      exp_d = '{4'd6, 4'hA, 4'hF};
      exp_bo = '{1'b0, 1'b1, 1'b1};
      ndone = 0;
      start = 1'b0;
      @(negedge clk);
      for (int e = 1; e <= 18; e++) begin
         if ((e - 1) % 6 == 0) begin
            in_a = ops_a[(e - 1) / 6]; in_b = ops_b[(e - 1) / 6]; in_bi = ops_bi[(e - 1) / 6];
         end else begin
            in_a = W'($urandom); in_b = W'($urandom); in_bi = $urandom_range(0, 1) == 1;
         end
         start = 1'b1;
         @(negedge clk);
         if (done === 1'b1) ndone++;
         if (e % 6 == 5) begin
            n_cmp++;
            if (done !== 1'b1 || out_d !== exp_d[(e - 5) / 6] || out_bo !== exp_bo[(e - 5) / 6]) begin
               n_err++;
               $display("FAIL held_result op%0d: got done=%b d=%0d bo=%b expected 1 %0d %b",
                        (e - 5) / 6, done, out_d, out_bo, exp_d[(e - 5) / 6], exp_bo[(e - 5) / 6]);
            end
         end else if (done !== 1'b0) begin
            n_cmp++;
            n_err++;
            $display("FAIL held_spurious_done edge%0d: got done=%b expected 0", e, done);
         end
      end
      start = 1'b0;
      n_cmp++;
      if (ndone != 3) begin
         n_err++;
         $display("FAIL held_done_count: got %0d expected 3", ndone);
      end
   endtask

`ifdef SERIAL_RESTADOR_OVF_EN
   task automatic test_ovf;
      int nb;
      logic seen;
      run_op(4'd8, 4'd1, 1'b0, nb, seen);
      n_cmp++;
      if (!seen || out_d !== 4'd7 || out_ov !== 1'b1) begin
         n_err++;
         $display("FAIL ovf_8m1: got done=%b d=%0d ov=%b expected 1 7 1", seen, out_d, out_ov);
      end
      run_op(4'd7, 4'd1, 1'b0, nb, seen);
      n_cmp++;
      if (!seen || out_d !== 4'd6 || out_ov !== 1'b0) begin
         n_err++;
         $display("FAIL ovf_7m1: got done=%b d=%0d ov=%b expected 1 6 0", seen, out_d, out_ov);
      end
   endtask
`endif

   task automatic test_abort_reset;
      int start_cnt;
      int nb;
      logic seen;
      // leave a nonzero result on the outputs so the reset clear is observable
      run_op(4'd0, 4'd0, 1'b1, nb, seen);
      @(negedge clk);
      start_cnt = done_cnt;
      in_a = 4'd9; in_b = 4'd3; in_bi = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({busy, done, out_d, out_bo} !== 7'b0) begin
         n_err++;
         $display("FAIL abort_clear: got %b expected %b", {busy, done, out_d, out_bo}, 7'b0);
      end
      @(negedge clk);
      rst = 1'b0;
      in_a = 4'd5; in_b = 4'd5; in_bi = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nb = 0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (busy === 1'b1) nb++;
         @(negedge clk);
      end
      n_cmp++;
      if (!seen || nb != 4 || out_d !== 4'd0 || out_bo !== 1'b0) begin
         n_err++;
         $display("FAIL restart_5m5: got done=%b busy_cycles=%0d d=%0d bo=%b expected 1 4 0 0",
                  seen, nb, out_d, out_bo);
      end
      @(negedge clk);
      n_cmp++;
      if (done_cnt - start_cnt != 1) begin
         n_err++;
         $display("FAIL abort_done_count: got %0d expected 1", done_cnt - start_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_exhaustive();
      test_start_held();
`ifdef SERIAL_RESTADOR_OVF_EN
      test_ovf();
`endif
      test_abort_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
